vec_lane_exec: RTL
==================

# vec_lane_exec

Vector execution sequencer that sits directly upstream of the vector register file (vrf) write port and downstream of its read ports. It accepts one arithmetic vector instruction, vector-vector or vector-scalar, and streams the source vectors out of the vrf `lanes_p` elements per beat. It computes per-lane add/sub/mult, writes the results back into the destination vector, then signals completion with a valid/yumi handshake.

## Interface
Parameters:
- `els_p`, 32, number of vectors in the vrf
- `vlen_p`, 8, elements per vector; must be a multiple of `lanes_p`
- `vdw_p`, 8, bits per element
- `lanes_p`, 4, elements processed per beat; `beats = vlen_p/lanes_p`
- derived: `v_addr_width_lp = clog2(els_p)`, `local_addr_width_lp = clog2(vlen_p)`, `addr_width_lp = v_addr_width_lp + local_addr_width_lp`

Ports:
- `clk_i` in 1: single clock
- `reset_i` in 1: asynchronous, active-high reset
- `v_i` in 1: instruction valid
- `ready_o` out 1: instruction accepted when `v_i & ready_o`
- `op_i` in 3: operation; bit2 selects scalar operand; [1:0] is 00 add, 01 sub, 10 mult, 11 illegal
- `vs1_i`, `vs2_i`, `vd_i` in `v_addr_width_lp` each: source 1, source 2 and destination vector indices
- `scalar_i` in `vdw_p`: scalar operand, used when `op_i[2]`
- `r0_addr_o`, `r1_addr_o` out `addr_width_lp`: vrf read addresses, `{vector, element}`; element is lane-group aligned
- `r0_data_i`, `r1_data_i` in `lanes_p*vdw_p`: vrf read data; combinational, same cycle
- `w_addr_o` out `addr_width_lp`, `w_data_o` out `lanes_p*vdw_p`, `w_en_o` out 1: vrf write port
- `v_o` out 1: instruction complete
- `yumi_i` in 1: completion consumed; legal only while `v_o`

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `ready_o=1`. On `v_i`, latch op, vs1, vs2, vd and scalar, clear the beat counter, and go to RUN.
- RUN: read beat `b`, with `r0_addr_o={vs1,b*lanes_p}` and `r1_addr_o={vs2,b*lanes_p}`.
  - Lane `i` operand A is r0 element `i`. Operand B is `scalar` if op[2], else r1 element `i`. Element `i` is at bits `[i*vdw_p +: vdw_p]`.
  - The result is registered into a write stage with `{vd,b*lanes_p}`, and the stage's valid bit is set.
  - `b` increments; after `b=beats-1`, go to DRAIN.
- The write stage drives `w_*` one cycle after the matching read, so beat `b` is written during the read of beat `b+1`. The two touch disjoint elements, so `vd==vs1` or `vd==vs2` is hazard-free.
- DRAIN: write the final beat, no read, then go to DONE.
- DONE: `v_o=1` until `yumi_i`, then return to IDLE.
- Arithmetic: unsigned modulo 2^`vdw_p`. Mult keeps the low `vdw_p` bits of the product.
- Illegal op (x11): the full sequence runs, but `w_en_o` is never asserted; completion is still signalled.
- Read addresses are don't-care outside RUN. `w_en_o=0` outside writes.

## Timing
- Reset values: `ready_o=1`, `v_o=0`, `w_en_o=0`, state IDLE, write-stage valid 0.
- Reset mid-operation immediately (asynchronously) clears `w_en_o`, discards the instruction and returns to IDLE.
- With the accept edge at cycle 0:
  - RUN occupies cycles 1..beats.
  - Writes occur in cycles 2..beats+1; the last is in DRAIN.
  - `v_o` rises in cycle beats+2.
- Defaults (beats=2): reads in cycles 1–2, writes in cycles 2–3, `v_o` in cycle 4.
- `yumi_i` in the same cycle `v_o` rises is legal. `ready_o` is then high the next cycle, so back-to-back instructions have one IDLE cycle between them.
- `ready_o` stays low from the accept edge until the yumi edge. `v_i` while not ready is ignored.

## Structure
- Shared package `vec_pkg`: op encoding constants (`OP_ADD=2'b00`, `OP_SUB`, `OP_MUL`, `OP_SCALAR_BIT=2`) and the state enum `vec_exec_state_e`.
- Sub-module `vec_lane_alu`: a combinational single-lane `vdw_p`-bit add/sub/mult with an operand-B mux, instantiated `lanes_p` times through a generate loop.
- Sequencer, beat counter and write stage live in `vec_lane_exec`.

## Test plan
- Vector-vector add: v1={1..8}, v2={10,...,10}, op 000, vd=3 -> v3={11..18}; writes at cycles 2 and 3 to addresses {3,0} and {3,4}; `v_o` at cycle 4.
- Sub wrap and mult truncation: v1 element 3, v2 element 5, op 001 -> 254 (0xFE). Elements 16×17, op 010 -> 0x10 (272 mod 256).
- Vector-scalar: v1={1..8}, scalar=7, op 110 -> vd={7,14,...,56}; r1 data is ignored, proven by driving r1 with all-ones.
- In-place, vd==vs1=5: add v5+v2 -> v5 correct on every element, with no corrupted beat.
- Backpressure and back-to-back: hold `yumi_i=0` for 10 cycles -> `v_o` stays high, `ready_o` low, no writes. Then yumi; a second instruction is accepted the next cycle with correct results.
- Reset asserted in cycle 2 of RUN -> `w_en_o` drops immediately, `ready_o=1` and `v_o=0` after reset, no later writes. An illegal op 011 -> no `w_en_o` ever, `v_o` at cycle 4.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared definitions for the vector execution sequencer: op encoding,
// decoded op struct and sequencer state enum.
package vec_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;
  localparam int         OP_SCALAR_BIT = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } vec_exec_state_e;

  typedef struct packed {
    logic       scalar;
    logic [1:0] fn;
  } vec_op_t;

  function automatic logic op_legal(input logic [1:0] fn);
    return fn != OP_ILL;
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Single-lane combinational ALU: unsigned modulo add/sub/mult with operand-B
// selection between the vrf element and the latched scalar.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int vdw_p = 8
) (
  input  logic [1:0]       fn_i,
  input  logic             scalar_sel_i,
  input  logic [vdw_p-1:0] a_i,
  input  logic [vdw_p-1:0] r1_i,
  input  logic [vdw_p-1:0] scalar_i,
  output logic [vdw_p-1:0] res_o
);

  logic [vdw_p-1:0] b;

  assign b = scalar_sel_i ? scalar_i : r1_i;

  // Same-width operands keep only the low vdw_p bits of the product.
  always_comb begin
    res_o = '0;
    case (fn_i)
      OP_ADD:  res_o = a_i + b;
      OP_SUB:  res_o = a_i - b;
      OP_MUL:  res_o = a_i * b;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/vec_lane_exec.sv
// Vector execution sequencer: streams two source vectors from the vrf a lane
// group per beat, computes per-lane results and writes them back one cycle later.
module vec_lane_exec
  import vec_pkg::*;
#(
  parameter  int els_p   = 32,
  parameter  int vlen_p  = 8,
  parameter  int vdw_p   = 8,
  parameter  int lanes_p = 4,
  localparam int v_addr_width_lp     = $clog2(els_p),
  localparam int local_addr_width_lp = $clog2(vlen_p),
  localparam int addr_width_lp       = v_addr_width_lp + local_addr_width_lp
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       v_i,
  output logic                       ready_o,
  input  logic [2:0]                 op_i,
  input  logic [v_addr_width_lp-1:0] vs1_i,
  input  logic [v_addr_width_lp-1:0] vs2_i,
  input  logic [v_addr_width_lp-1:0] vd_i,
  input  logic [vdw_p-1:0]           scalar_i,
  output logic [addr_width_lp-1:0]   r0_addr_o,
  output logic [addr_width_lp-1:0]   r1_addr_o,
  input  logic [lanes_p*vdw_p-1:0]   r0_data_i,
  input  logic [lanes_p*vdw_p-1:0]   r1_data_i,
  output logic [addr_width_lp-1:0]   w_addr_o,
  output logic [lanes_p*vdw_p-1:0]   w_data_o,
  output logic                       w_en_o,
  output logic                       v_o,
  input  logic                       yumi_i
);

  localparam int LAW = local_addr_width_lp;
  localparam logic [LAW-1:0] LAST_ELEM = LAW'(vlen_p - lanes_p);
  localparam logic [LAW-1:0] ELEM_STEP = LAW'(lanes_p);

  vec_exec_state_e state_q, state_d;

  vec_op_t                    op_q;
  logic [v_addr_width_lp-1:0] vs1_q, vs2_q, vd_q;
  logic [vdw_p-1:0]           scalar_q;
  logic [LAW-1:0]             elem_q;
  logic                       accept;
  logic                       last_beat;

  logic                     wvld_q;
  logic [addr_width_lp-1:0] waddr_q;
  logic [lanes_p-1:0][vdw_p-1:0] wdata_q;

  logic [lanes_p-1:0][vdw_p-1:0] r0_lanes, r1_lanes, res;

  assign r0_lanes  = r0_data_i;
  assign r1_lanes  = r1_data_i;
  assign last_beat = (elem_q == LAST_ELEM);

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    v_o     = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN:   if (last_beat) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        v_o = 1'b1;
        if (yumi_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      scalar_q <= '0;
      elem_q   <= '0;
    end else if (accept) begin
      op_q.scalar <= op_i[OP_SCALAR_BIT];
      op_q.fn     <= op_i[1:0];
      vs1_q       <= vs1_i;
      vs2_q       <= vs2_i;
      vd_q        <= vd_i;
      scalar_q    <= scalar_i;
      elem_q      <= '0;
    end else if (state_q == S_RUN) begin
      elem_q <= elem_q + ELEM_STEP;
    end
  end

  assign r0_addr_o = {vs1_q, elem_q};
  assign r1_addr_o = {vs2_q, elem_q};

  for (genvar i = 0; i < lanes_p; i++) begin : g_lane
    vec_lane_alu #(.vdw_p(vdw_p)) u_alu (
      .fn_i         (op_q.fn),
      .scalar_sel_i (op_q.scalar),
      .a_i          (r0_lanes[i]),
      .r1_i         (r1_lanes[i]),
      .scalar_i     (scalar_q),
      .res_o        (res[i])
    );
  end

  // Write stage: beat b lands while beat b+1 is read; disjoint elements make
  // vd aliasing a source safe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wvld_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wvld_q <= (state_q == S_RUN);
      if (state_q == S_RUN) begin
        waddr_q <= {vd_q, elem_q};
        wdata_q <= res;
      end
    end
  end

  assign w_en_o   = wvld_q & op_legal(op_q.fn);
  assign w_addr_o = waddr_q;
  assign w_data_o = wdata_q;

endmodule
